// File: rtl/gray_seq_ctrl_if.sv
// Command/status bundle between a command source (master) and gray_seq_ctrl (slave).
interface gray_seq_ctrl_if #(
  parameter int N = 3
);
  logic         start;
  logic         up_dn;
  logic [N-1:0] target;
  logic         pause;
  logic         stop;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] gray_out;
  logic         busy;
  logic         done;
  logic         wrap;
  logic [N:0]   steps;
  logic         err;

  modport master (
    output start, up_dn, target, pause, stop, load, load_val,
    input  gray_out, busy, done, wrap, steps, err
  );

  modport slave (
    input  start, up_dn, target, pause, stop, load, load_val,
    output gray_out, busy, done, wrap, steps, err
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Gray-code run controller: steps an N-bit Gray counter up/down to a latched target.
// Optional macro GRAY_CHK_EN adds a sticky single-bit-change checker on err.
module gray_seq_ctrl #(
  parameter int N = 3
) (
  input  logic          clk,
  input  logic          reset,
  gray_seq_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N-1:0] ONE_N     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   ONE_S     = {{N{1'b0}}, 1'b1};
  localparam logic [N:0]   STEPS_MAX = {1'b1, {N{1'b0}}};

  logic [1:0]   r_state;
  logic [N-1:0] r_gray;
  logic [N-1:0] r_target;
  logic         r_up;
  logic [N:0]   r_steps;
  logic         r_busy;
  logic         r_done;
  logic         r_wrap;

  logic [N-1:0] w_bin;
  logic [N-1:0] w_bin_step;
  logic [N-1:0] w_gray_step;
  logic         w_wrap;

  // Binary bit i is the XOR of Gray bits i..N-1.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_g2b
      assign w_bin[gi] = ^(r_gray >> gi);
    end
  endgenerate

  assign w_bin_step  = r_up ? (w_bin + ONE_N) : (w_bin - ONE_N);
  assign w_gray_step = w_bin_step ^ (w_bin_step >> 1);
  assign w_wrap      = r_up ? (&w_bin) : ~(|w_bin);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gray   <= '0;
      r_target <= '0;
      r_up     <= 1'b1;
      r_steps  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load) r_gray <= bus.load_val;
          if (bus.start) begin
            r_target <= bus.target;
            r_up     <= bus.up_dn;
            r_steps  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.pause) begin
            r_state <= S_PAUSE;
          end else begin
            r_gray <= w_gray_step;
            r_wrap <= w_wrap;
            if (r_steps != STEPS_MAX) r_steps <= r_steps + ONE_S;
            // Target is compared against the new code, so target == start means a full lap.
            if (w_gray_step == r_target) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (bus.stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!bus.pause) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gray_out = r_gray;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.wrap     = r_wrap;
  assign bus.steps    = r_steps;

`ifdef GRAY_CHK_EN
  logic [N-1:0] r_gray_prev;
  logic         r_chk_valid;
  logic         r_err;
  logic [N-1:0] w_diff;

  assign w_diff = r_gray ^ r_gray_prev;

  // A load rewrites the count arbitrarily, so the following comparison is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gray_prev <= '0;
      r_chk_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_gray_prev <= r_gray;
      r_chk_valid <= !((r_state == S_IDLE) && bus.load);
      if (r_chk_valid && ((w_diff & (w_diff - ONE_N)) != '0)) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (N = 3): table runs, corner sequences, random runs.
module tb_gray_seq_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.N(N)) bus ();

  gray_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] load_val;
    logic [2:0] target;
    logic       up;
    int         exp_steps;
    int         exp_wraps;
  } run_vec_t;

  run_vec_t   vecs [5];
  logic [2:0] gt [8];
  int         n_checks = 0;
  int         n_err    = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (gt[i] == g) return i;
    return 0;
  endfunction

  // Load lv, start toward tg, follow each advance against the code-table model.
  task automatic run_and_check(input logic [2:0] lv, input logic [2:0] tg, input logic up,
                               input int exp_steps, input int exp_wraps, input bit mid_load);
    int  idx;
    int  cnt;
    int  wraps;
    bit  exp_wrap;
    bit  finished;
    idx = idx_of(lv);
    cnt = 0;
    wraps = 0;
    finished = 0;
    bus.load = 1'b1; bus.load_val = lv;
    tick();
    bus.load = 1'b0; bus.start = 1'b1; bus.target = tg; bus.up_dn = up;
    tick();
    bus.start = 1'b0; bus.target = 3'($urandom); bus.up_dn = ~up;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_steps", 32'(bus.steps), 32'd0);
    chk("start_gray", 32'(bus.gray_out), 32'(lv));
    for (int c = 0; c < 12; c++) begin
      if (mid_load) begin
        bus.load = 1'b1; bus.load_val = 3'($urandom);
      end
      tick();
      exp_wrap = up ? (idx == 7) : (idx == 0);
      idx = up ? (idx + 1) % 8 : (idx + 7) % 8;
      cnt++;
      chk("step_gray", 32'(bus.gray_out), 32'(gt[idx]));
      chk("step_wrap", 32'(bus.wrap), 32'(exp_wrap));
      if (bus.wrap === 1'b1) wraps++;
      if (gt[idx] == tg) begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_steps", 32'(bus.steps), 32'(cnt));
        finished = 1;
        break;
      end
      chk("run_no_done", 32'(bus.done), 32'd0);
    end
    bus.load = 1'b0;
    chk("run_finished", 32'(finished), 32'd1);
    chk("run_steps", 32'(cnt), 32'(exp_steps));
    chk("run_wraps", 32'(wraps), 32'(exp_wraps));
    tick();
    chk("after_done", 32'(bus.done), 32'd0);
    chk("after_busy", 32'(bus.busy), 32'd0);
    chk("after_steps", 32'(bus.steps), 32'(exp_steps));
    chk("after_gray", 32'(bus.gray_out), 32'(tg));
    $display("run lv=%b tg=%b up=%0d steps=%0d wraps=%0d", lv, tg, up, cnt, wraps);
  endtask

  initial begin
    logic [2:0] lv;
    logic [2:0] tg;
    logic       up;
    int         is;
    int         it;
    int         d;
    int         w;

    for (int i = 0; i < 8; i++) gt[i] = 3'(i ^ (i >> 1));
    vecs[0] = '{3'b000, 3'b101, 1'b1, 6, 0};
    vecs[1] = '{3'b001, 3'b110, 1'b0, 5, 1};
    vecs[2] = '{3'b011, 3'b011, 1'b1, 8, 1};
    vecs[3] = '{3'b110, 3'b111, 1'b1, 1, 0};
    vecs[4] = '{3'b000, 3'b100, 1'b0, 1, 1};

    reset = 1'b1;
    bus.start = 1'b0; bus.up_dn = 1'b1; bus.target = '0; bus.pause = 1'b0;
    bus.stop = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    tick();
    tick();
    chk("rst_gray", 32'(bus.gray_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    chk("rst_steps", 32'(bus.steps), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a run
    bus.load = 1'b1; bus.load_val = 3'b000;
    tick();
    bus.load = 1'b0; bus.start = 1'b1; bus.target = 3'b101; bus.up_dn = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("midrst_pre_gray", 32'(bus.gray_out), 32'b010);
    chk("midrst_pre_steps", 32'(bus.steps), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_gray", 32'(bus.gray_out), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_steps", 32'(bus.steps), 32'd0);
    tick();
    chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
    chk("midrst_idle_gray", 32'(bus.gray_out), 32'd0);
    $display("reset mid-run sequence done");

    for (int v = 0; v < 5; v++)
      run_and_check(vecs[v].load_val, vecs[v].target, vecs[v].up,
                    vecs[v].exp_steps, vecs[v].exp_wraps, 1'b0);

    // Pause for three cycles, resume, then abort
    bus.load = 1'b1; bus.load_val = 3'b000;
    tick();
    bus.load = 1'b0; bus.start = 1'b1; bus.target = 3'b100; bus.up_dn = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("pause_pre_gray", 32'(bus.gray_out), 32'b011);
    bus.pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("pause_gray", 32'(bus.gray_out), 32'b011);
      chk("pause_busy", 32'(bus.busy), 32'd1);
      chk("pause_done", 32'(bus.done), 32'd0);
    end
    bus.pause = 1'b0;
    tick();
    chk("resume_hold_gray", 32'(bus.gray_out), 32'b011);
    chk("resume_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("resume_step_gray", 32'(bus.gray_out), 32'b010);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_gray", 32'(bus.gray_out), 32'b010);
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_done", 32'(bus.done), 32'd0);
    chk("stop_steps", 32'(bus.steps), 32'd3);
    tick();
    chk("stop_idle_done", 32'(bus.done), 32'd0);
    chk("stop_idle_gray", 32'(bus.gray_out), 32'b010);
    $display("pause/stop sequence done");

    // Load and start together; load mid-run and start in DONE are ignored
    bus.load = 1'b1; bus.load_val = 3'b111; bus.start = 1'b1; bus.target = 3'b000; bus.up_dn = 1'b1;
    tick();
    bus.start = 1'b0; bus.load_val = 3'b010;
    chk("ls_busy", 32'(bus.busy), 32'd1);
    chk("ls_gray", 32'(bus.gray_out), 32'b111);
    tick();
    chk("ls_step1", 32'(bus.gray_out), 32'b101);
    chk("ls_step1_wrap", 32'(bus.wrap), 32'd0);
    tick();
    chk("ls_step2", 32'(bus.gray_out), 32'b100);
    chk("ls_step2_done", 32'(bus.done), 32'd0);
    tick();
    chk("ls_step3", 32'(bus.gray_out), 32'b000);
    chk("ls_step3_wrap", 32'(bus.wrap), 32'd1);
    chk("ls_step3_done", 32'(bus.done), 32'd1);
    chk("ls_steps", 32'(bus.steps), 32'd3);
    bus.start = 1'b1; bus.target = 3'b001;
    tick();
    bus.start = 1'b0; bus.load = 1'b0;
    chk("ls_done_start_busy", 32'(bus.busy), 32'd0);
    chk("ls_done_gray", 32'(bus.gray_out), 32'b000);
    tick();
    chk("ls_idle_busy", 32'(bus.busy), 32'd0);
    chk("ls_idle_steps", 32'(bus.steps), 32'd3);
    $display("load+start sequence done");

    // Random runs; expected length and wrap count from modular index distance
    for (int r = 0; r < 24; r++) begin
      lv = 3'($urandom);
      tg = 3'($urandom);
      up = 1'($urandom);
      is = idx_of(lv);
      it = idx_of(tg);
      d  = up ? (it - is + 8) % 8 : (is - it + 8) % 8;
      if (d == 0) d = 8;
      w  = up ? ((is + d > 7) ? 1 : 0) : ((is - d < 0) ? 1 : 0);
      run_and_check(lv, tg, up, d, w, 1'($urandom));
    end

    chk("final_err", 32'(bus.err), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
Run controller for an N-bit Gray-code counter datapath. Takes a start/target command, steps the Gray counter up or down one code per cycle until the target code is reached, then pulses done. Supports pause, abort, preload and wrap signalling. Sits between a command source (testbench, top-level FSM) and any logic consuming the Gray count.

Parameters:
N, 3, Gray counter width in bits (N >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command; accepted only in IDLE
up_dn  in  1  direction, 1 = up, 0 = down; latched on accepted start
target  in  N  Gray code at which the run ends; latched on accepted start
pause  in  1  level; holds the counter while high during a run
stop  in  1  abort the run; return to IDLE without done
load  in  1  preload the counter; accepted only in IDLE
load_val  in  N  Gray value written on accepted load
gray_out  out  N  current Gray count (registered)
busy  out  1  high in RUN and PAUSE
done  out  1  one-cycle pulse when the target is reached
wrap  out  1  one-cycle pulse on a wrap step
steps  out  N+1  number of advances in the current or last run
err  out  1  sticky Gray-adjacency error (optional feature only)

Behaviour:
- Reset: synchronous, active-high. On reset, state = IDLE, gray_out = 0, steps = 0, busy = 0, done = 0, wrap = 0, err = 0. Reset overrides every other input, including mid-run.
- States are IDLE, RUN, PAUSE and DONE.
- IDLE:
  - load = 1 sets gray_out = load_val.
  - start = 1 latches target and up_dn, clears steps and moves to RUN.
  - If load and start arrive in the same cycle, load applies and the run starts from load_val.
- RUN: every cycle the counter advances one Gray code in the latched direction and steps increments.
  - Stepping is done by Gray -> binary, +/-1 mod 2^N, then binary -> Gray. Exactly one bit changes per step.
  - Input priority: stop > pause > advance.
  - stop = 1 moves to IDLE with gray_out held and no done.
  - pause = 1 moves to PAUSE with no advance that cycle.
- PAUSE: gray_out is held.
  - stop = 1 moves to IDLE.
  - pause = 0 moves to RUN; advancing resumes on the next cycle.
- Termination: the advancing edge that makes gray_out equal the latched target moves the state to DONE. done = 1 for exactly the DONE cycle, then the state returns to IDLE. start is ignored while in DONE.
- Target equal to the start value: this is a full revolution, 2^N advances, then done. Zero-length runs do not exist.
- Latency: start is sampled at edge k, so busy = 1 after edge k. The first gray_out change follows edge k+1. done appears D cycles after busy, where D = number of advances.
- wrap pulses for one cycle after a step from binary 2^N-1 to 0 (up) or from 0 to 2^N-1 (down). For N = 3, this is Gray 100 -> 000 (up) or 000 -> 100 (down).
- steps saturates at 2^N, is held after the run, and clears on the next accepted start.
- load and start outside IDLE are ignored. target and up_dn changes mid-run have no effect.
- busy is registered and low in IDLE and DONE.

Optional Feature:
GRAY_CHK_EN
- Defined: a checker compares each new gray_out with its previous value. If a cycle changes gray_out by a bit count other than 0 or 1 (excluding the load cycle and the reset cycle), err is set and stays set until reset.
- Not defined: err is tied to 0 and no checker logic is generated.

Test Plan:
1. Reset mid-run (N = 3): run up from 000, assert reset after 3 advances -> next cycle gray_out = 000, busy = 0, steps = 0, state IDLE; a new start works normally.
2. Up run: from 000, start with target = 101, up_dn = 1 -> gray_out goes 001, 011, 010, 110, 111, 101. done pulses once, 6 cycles after busy rises; steps = 6; wrap never asserts.
3. Down run with wrap: load 001, start with target = 110, up_dn = 0 -> sequence 000, 100, 101, 111, 110. wrap pulses after the 000 -> 100 step; done after 5 advances.
4. Full revolution: gray_out = 011, start with target = 011, up -> 8 advances, one wrap, done with steps = 8.
5. Pause and stop: up run to target 100, pause for 3 cycles after 2 advances -> gray_out holds 011, busy = 1. Release pause, then stop after 1 advance -> gray_out = 010, IDLE, done never asserted.
6. Simultaneous and ignored inputs: load 111 and start in the same cycle, target 000, up -> first advance gives 101, done after 3 advances. load asserted during the run is ignored.
